// File: rtl/mdc_fft_pkg.sv
// Shared types, width defaults and the saturation helper for the MDC FFT datapath.
package mdc_fft_pkg;

  localparam int DW_DEF   = 16;
  localparam int TW_DEF   = 9;
  localparam int FRAC_DEF = 7;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  // Clamp a sign-extended value to the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi)      sat_dw = hi;
    else if (x < lo) sat_dw = lo;
    else             sat_dw = x;
  endfunction

endpackage

// File: rtl/mdc_cmul.sv
// 3-stage complex multiply, round and saturate. MDC_TWMUL_ROUND_EN selects
// round-half-up; otherwise the post-multiply shift truncates toward -inf.
module mdc_cmul
  import mdc_fft_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int TW   = TW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [TW-1:0] w_r,
  input  logic signed [TW-1:0] w_i,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i
);

  localparam int STAGES = 3;
  localparam int PW     = DW + TW;
  localparam int SW     = DW + TW + 1;

`ifdef MDC_TWMUL_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC - 1);
`else
  localparam logic signed [SW-1:0] RND = '0;
`endif

  logic [STAGES-1:0]   vld_pipe;
  logic signed [DW-1:0] s1_dr, s1_di;
  logic signed [TW-1:0] s1_wr, s1_wi;
  logic signed [PW-1:0] pr, pi, qr, qi;
  logic signed [SW-1:0] sr, si, sr_sh, si_sh;

  // Only the valid bits are reset; data registers are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
  end

  always_ff @(posedge clk) begin
    s1_dr <= in_r;
    s1_di <= in_i;
    s1_wr <= w_r;
    s1_wi <= w_i;
    pr    <= PW'(s1_dr) * PW'(s1_wr);
    pi    <= PW'(s1_di) * PW'(s1_wi);
    qr    <= PW'(s1_dr) * PW'(s1_wi);
    qi    <= PW'(s1_di) * PW'(s1_wr);
  end

  always_comb begin
    sr    = SW'(pr) - SW'(pi);
    si    = SW'(qr) + SW'(qi);
    sr_sh = (sr + RND) >>> FRAC;
    si_sh = (si + RND) >>> FRAC;
  end

  // Output words hold their last product across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= '0;
      out_i <= '0;
    end else if (vld_pipe[1]) begin
      out_r <= DW'(sat_dw(64'(sr_sh), DW));
      out_i <= DW'(sat_dw(64'(si_sh), DW));
    end
  end

  assign out_valid = vld_pipe[STAGES-1];

endmodule

// File: rtl/mdc_twiddle_mul.sv
// Twiddle stage of the 32-point MDC FFT: steps the twiddle ROM index and multiplies
// each valid sample by the returned twiddle. MDC_TWMUL_ROUND_EN enables rounding.
module mdc_twiddle_mul
  import mdc_fft_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int TW     = TW_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int CNT_W  = 1,
  parameter int NUM_TW = 2,
  parameter int HOLD   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic                 din_sof,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [TW-1:0] w_r,
  input  logic signed [TW-1:0] w_i,
  output logic [CNT_W-1:0]     rom_counter,
  output logic                 dout_valid,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i
);

  localparam int SMP_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_TW - 1);
  // Counter state just after consuming the SOF sample of a fresh frame.
  localparam logic [SMP_W-1:0] SOF_SMP  = SMP_W'((HOLD == 1) ? 0 : 1);
  localparam logic [CNT_W-1:0] SOF_IDX  = CNT_W'((HOLD == 1 && NUM_TW > 1) ? 1 : 0);

  logic [SMP_W-1:0] smp_q;
  logic [CNT_W-1:0] idx_q;
  logic             sof_acc;

  assign sof_acc = din_valid & din_sof;

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q <= '0;
      idx_q <= '0;
    end else if (sof_acc) begin
      smp_q <= SOF_SMP;
      idx_q <= SOF_IDX;
    end else if (din_valid) begin
      if (smp_q == SMP_LAST) begin
        smp_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + CNT_W'(1);
      end else begin
        smp_q <= smp_q + SMP_W'(1);
      end
    end
  end

  assign rom_counter = sof_acc ? '0 : idx_q;

  mdc_cmul #(
    .DW   (DW),
    .TW   (TW),
    .FRAC (FRAC)
  ) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (din_valid),
    .in_r      (din_r),
    .in_i      (din_i),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (dout_valid),
    .out_r     (dout_r),
    .out_i     (dout_i)
  );

endmodule

// File: tb/tb_mdc_twiddle_mul.sv
// Directed bench for mdc_twiddle_mul: vector table with forced twiddles, then ROM-index
// sequencing, bubbles, mid-frame SOF and mid-stream reset against a latency scoreboard.
module tb_mdc_twiddle_mul;
  import mdc_fft_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              din_valid, din_sof;
  logic signed [15:0] din_r, din_i;
  logic signed [8:0]  w_r, w_i;
  logic [0:0]        rom_counter;
  logic              dout_valid;
  logic signed [15:0] dout_r, dout_i;

  always #5 clk = ~clk;

  mdc_twiddle_mul dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof),
    .din_r(din_r), .din_i(din_i), .w_r(w_r), .w_i(w_i),
    .rom_counter(rom_counter), .dout_valid(dout_valid),
    .dout_r(dout_r), .dout_i(dout_i)
  );

  // Bench-side ROM: twiddle 0 = +1, twiddle 1 = -j; forced values override it.
  logic              force_w;
  logic signed [8:0] fw_r, fw_i;
  always_comb begin
    w_r = (rom_counter == 1'b0) ? 9'sd128 : 9'sd0;
    w_i = (rom_counter == 1'b0) ? 9'sd0   : -9'sd128;
    if (force_w) begin
      w_r = fw_r;
      w_i = fw_i;
    end
  end

  typedef struct { cplx_t d; int wr; int wi; cplx_t e; } vec_t;
  typedef struct { logic v; cplx_t e; } exp_t;

  vec_t  vt[9];
  exp_t  sb[$];
  cplx_t last_e;
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic cplx_t mk(int r, int i);
    cplx_t c;
    c.re = 16'(r);
    c.im = 16'(i);
    return c;
  endfunction

  // Product with the bench ROM twiddle: +1 or -j.
  function automatic cplx_t model(int rc, cplx_t d);
    if (rc == 0) return d;
    return mk(int'(d.im), -int'(d.re));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; the entry pushed three cycles ago is due at the output now.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() == 3) begin
      x = sb.pop_front();
      chk("dout_valid", int'(dout_valid), int'(x.v));
      if (x.v) begin
        chk("dout_r", int'(dout_r), int'(x.e.re));
        chk("dout_i", int'(dout_i), int'(x.e.im));
        last_e = x.e;
      end else begin
        chk("dout_r_hold", int'(dout_r), int'(last_e.re));
        chk("dout_i_hold", int'(dout_i), int'(last_e.im));
      end
    end
  endtask

  task automatic step(input logic v, input logic sof, input cplx_t d, input int rc, input cplx_t e);
    exp_t x;
    din_valid = v;
    din_sof   = sof;
    din_r     = d.re;
    din_i     = d.im;
    #1;
    if (rc >= 0) chk("rom_counter", int'(rom_counter), rc);
    x.v = v;
    x.e = e;
    sb.push_back(x);
    tick();
  endtask

  task automatic bubble(input int rc);
    step(1'b0, 1'b0, mk(0, 0), rc, mk(0, 0));
  endtask

  initial begin
    int    rc_a[10];
    int    rc_c[10];
    cplx_t d;

    rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0; din_r = '0; din_i = '0;
    force_w = 1'b0; fw_r = '0; fw_i = '0; last_e = mk(0, 0);

    vt[0] = '{d: mk(1000, -500),     wr: 128, wi: 0,    e: mk(1000, -500)};
    vt[1] = '{d: mk(1000, -500),     wr: 0,   wi: -128, e: mk(-500, -1000)};
    vt[2] = '{d: mk(-32768, 0),      wr: 0,   wi: -128, e: mk(0, 32767)};
`ifdef MDC_TWMUL_ROUND_EN
    vt[3] = '{d: mk(-1, 0),          wr: 64,  wi: 0,    e: mk(0, 0)};
    vt[4] = '{d: mk(1, 0),           wr: 64,  wi: 0,    e: mk(1, 0)};
    vt[7] = '{d: mk(100, 200),       wr: 90,  wi: -90,  e: mk(211, 70)};
`else
    vt[3] = '{d: mk(-1, 0),          wr: 64,  wi: 0,    e: mk(-1, 0)};
    vt[4] = '{d: mk(1, 0),           wr: 64,  wi: 0,    e: mk(0, 0)};
    vt[7] = '{d: mk(100, 200),       wr: 90,  wi: -90,  e: mk(210, 70)};
`endif
    vt[5] = '{d: mk(32767, 32767),   wr: 128, wi: 0,    e: mk(32767, 32767)};
    vt[6] = '{d: mk(-32768, -32768), wr: 0,   wi: 128,  e: mk(32767, -32768)};
    vt[8] = '{d: mk(-7, 3),          wr: -128, wi: -128, e: mk(10, 4)};

    rc_a = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    rc_c = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset dout_valid", int'(dout_valid), 0);
    chk("reset dout_r", int'(dout_r), 0);
    chk("reset dout_i", int'(dout_i), 0);
    chk("reset rom_counter", int'(rom_counter), 0);
    rst = 1'b0;

    // Isolated samples through forced twiddles: exact latency, single-cycle valid.
    force_w = 1'b1;
    for (int k = 0; k < 9; k++) begin
      fw_r = 9'(vt[k].wr);
      fw_i = 9'(vt[k].wi);
      step(1'b1, 1'b0, vt[k].d, -1, vt[k].e);
      bubble(-1);
      bubble(-1);
    end
    bubble(-1);
    force_w = 1'b0;

    // SOF then 10 samples; a second SOF lands right at the frame boundary.
    for (int k = 0; k < 10; k++) begin
      d = mk(100 + 7 * k, -(50 + k));
      step(1'b1, (k == 0 || k == 8), d, rc_a[k], model(rc_a[k], d));
    end
    repeat (3) bubble(0);

    // Bubbles inside a frame: index holds and the output gap matches.
    for (int k = 0; k < 8; k++) begin
      d = mk(-300 + 11 * k, 20 * k);
      step(1'b1, (k == 0), d, (k < 4) ? 0 : 1, model((k < 4) ? 0 : 1, d));
      if (k == 2) repeat (3) bubble(0);
      if (k == 5) bubble(1);
    end
    repeat (3) bubble(0);

    // SOF on the 6th sample restarts the twiddle sequence.
    for (int k = 0; k < 10; k++) begin
      d = mk(40 * k + 1, 3 - k);
      step(1'b1, (k == 0 || k == 5), d, rc_c[k], model(rc_c[k], d));
    end
    repeat (3) bubble(-1);

    // Reset with two samples in flight.
    for (int k = 0; k < 5; k++) begin
      d = mk(500 + k, 600 + k);
      step(1'b1, (k == 0), d, (k < 4) ? 0 : 1, model((k < 4) ? 0 : 1, d));
    end
    din_valid = 1'b0;
    din_sof   = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    last_e = mk(0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("post-reset rom_counter", int'(rom_counter), 0);
      chk("post-reset dout_valid", int'(dout_valid), 0);
      chk("post-reset dout_r", int'(dout_r), 0);
      chk("post-reset dout_i", int'(dout_i), 0);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 5; k++) begin
      d = mk(-20 - k, 9 * k);
      step(1'b1, 1'b0, d, (k < 4) ? 0 : 1, model((k < 4) ? 0 : 1, d));
    end
    repeat (4) bubble(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
